// File: rtl/fifo_win_sum_pkg.sv
// Shared helpers for the vertical window summer: width math and parameter sanity checks.
package fifo_win_sum_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_COLS   = 50;
    localparam int DEF_WIN    = 3;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Narrowest sum that can hold WIN full-scale unsigned samples.
    function automatic int sum_w_min(input int data_w, input int win);
        return data_w + clog2(win);
    endfunction

    localparam int DEF_SUM_W = sum_w_min(DEF_DATA_W, DEF_WIN);

    function automatic bit params_ok(input int data_w, input int cols,
                                     input int win, input int sum_w);
        return (data_w >= 1) && (cols >= 2) && (cols <= 1024) &&
               (win >= 2) && (win <= 8) && (sum_w >= sum_w_min(data_w, win));
    endfunction

endpackage

// File: rtl/fifo_win_sum_line_fifo.sv
// First-word-fall-through line buffer holding one matrix row; head is valid whenever not empty.
module line_fifo
    import fifo_win_sum_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 50
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] head,
    output logic              empty,
    output logic              full
);

    localparam int PW = clog2(DEPTH);
    localparam int CW = clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              do_push;
    logic              do_pop;

    // A full buffer still takes a word when the same cycle frees one.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push && !clr) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/fifo_win_sum.sv
// Streaming vertical window adder: sums each sample with the WIN-1 samples directly above it.
module fifo_win_sum
    import fifo_win_sum_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int COLS   = DEF_COLS,
    parameter int WIN    = DEF_WIN,
    parameter int SUM_W  = DEF_SUM_W
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              clr,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [SUM_W-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              row_full,
    output logic              busy_flag
);

    localparam int NF    = WIN - 1;
    localparam int CNT_W = clog2(COLS);
    localparam int ROW_W = clog2(WIN);

    if (!params_ok(DATA_W, COLS, WIN, SUM_W)) begin : g_param_check
        $error("fifo_win_sum: DATA_W/COLS/WIN/SUM_W out of range");
    end

    logic [CNT_W-1:0]  col_cnt;
    logic [ROW_W-1:0]  row_cnt;
    logic              accept;
    logic              steady;
    logic [NF-1:0]     push_vec;
    logic [NF-1:0]     pop_vec;
    logic [NF-1:0]     empty_vec;
    logic [NF-1:0]     full_vec;
    logic [DATA_W-1:0] heads [NF];
    logic [SUM_W-1:0]  win_sum;

    assign in_ready = !clr && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign row_full = (row_cnt == ROW_W'(WIN - 1));
    // Every line buffer is full exactly when row_full; requiring both keeps a stale head out of the sum.
    assign steady   = row_full && (&full_vec);
    assign busy_flag = out_valid || !(&empty_vec);

    // fifo[k] starts draining once it holds a complete row; its head cascades into fifo[k+1].
    always_comb begin
        pop_vec  = '0;
        push_vec = '0;
        push_vec[0] = accept;
        for (int k = 0; k < NF; k++) begin
            pop_vec[k] = accept && (row_cnt > ROW_W'(k));
        end
        for (int k = 1; k < NF; k++) begin
            push_vec[k] = pop_vec[k-1];
        end
    end

    for (genvar gk = 0; gk < NF; gk++) begin : g_fifo
        line_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (COLS)
        ) u_fifo (
            .clk   (sys_clk),
            .rst   (sys_rst),
            .clr   (clr),
            .push  (push_vec[gk]),
            .pop   (pop_vec[gk]),
            .din   ((gk == 0) ? in_data : heads[(gk == 0) ? 0 : gk - 1]),
            .head  (heads[gk]),
            .empty (empty_vec[gk]),
            .full  (full_vec[gk])
        );
    end

    always_comb begin
        win_sum = SUM_W'(in_data);
        for (int k = 0; k < NF; k++) begin
            win_sum = win_sum + SUM_W'(heads[k]);
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (clr) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (accept) begin
            if (col_cnt == CNT_W'(COLS - 1)) begin
                col_cnt <= '0;
                if (!row_full) begin
                    row_cnt <= row_cnt + ROW_W'(1);
                end
            end else begin
                col_cnt <= col_cnt + CNT_W'(1);
            end
        end
    end

    // Single output register: clr leaves a pending result in place so it is still delivered.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (accept && steady) begin
            out_valid <= 1'b1;
            out_data  <= win_sum;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_win_sum.sv
// Directed bench for fifo_win_sum: a COLS=4/WIN=3 instance and a COLS=3/WIN=2 instance.
module tb_fifo_win_sum;

    logic       clk = 1'b0;
    logic       rst;
    int         checks = 0;
    int         errors = 0;

    logic       clr;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [9:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       row_full;
    logic       busy_flag;

    logic       w2_clr;
    logic [7:0] w2_in_data;
    logic       w2_in_valid;
    logic       w2_in_ready;
    logic [8:0] w2_out_data;
    logic       w2_out_valid;
    logic       w2_out_ready;
    logic       w2_row_full;
    logic       w2_busy_flag;

    logic [9:0] exp_steady [8] = '{10'd12, 10'd15, 10'd18, 10'd21, 10'd24, 10'd27, 10'd30, 10'd33};
    logic [8:0] exp_w2 [6]     = '{9'd5, 9'd7, 9'd9, 9'd11, 9'd13, 9'd15};

    always #5 clk = ~clk;

    fifo_win_sum #(.DATA_W(8), .COLS(4), .WIN(3), .SUM_W(10)) dut3 (
        .sys_clk   (clk),
        .sys_rst   (rst),
        .clr       (clr),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .row_full  (row_full),
        .busy_flag (busy_flag)
    );

    fifo_win_sum #(.DATA_W(8), .COLS(3), .WIN(2), .SUM_W(9)) dut2 (
        .sys_clk   (clk),
        .sys_rst   (rst),
        .clr       (w2_clr),
        .in_data   (w2_in_data),
        .in_valid  (w2_in_valid),
        .in_ready  (w2_in_ready),
        .out_data  (w2_out_data),
        .out_valid (w2_out_valid),
        .out_ready (w2_out_ready),
        .row_full  (w2_row_full),
        .busy_flag (w2_busy_flag)
    );

    // Push into a full line buffer (without a same-cycle pop) or pop from an empty one must never happen.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if ((dut3.g_fifo[0].u_fifo.push && dut3.g_fifo[0].u_fifo.full && !dut3.g_fifo[0].u_fifo.pop) ||
                (dut3.g_fifo[0].u_fifo.pop && dut3.g_fifo[0].u_fifo.empty) ||
                (dut3.g_fifo[1].u_fifo.push && dut3.g_fifo[1].u_fifo.full && !dut3.g_fifo[1].u_fifo.pop) ||
                (dut3.g_fifo[1].u_fifo.pop && dut3.g_fifo[1].u_fifo.empty) ||
                (dut2.g_fifo[0].u_fifo.push && dut2.g_fifo[0].u_fifo.full && !dut2.g_fifo[0].u_fifo.pop) ||
                (dut2.g_fifo[0].u_fifo.pop && dut2.g_fifo[0].u_fifo.empty)) begin
                errors++;
                $display("[TB] FAIL fifo_overflow_underflow at %0t: got illegal push/pop, expected none", $time);
            end
        end
    end

    task automatic idle_inputs();
        clr = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
        w2_clr = 1'b0; w2_in_data = '0; w2_in_valid = 1'b0; w2_out_ready = 1'b1;
    endtask

    task automatic reset_dut();
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, out_data, row_full, busy_flag, in_ready} !== {1'b0, 10'd0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL reset_state: got v=%0b d=%0d rf=%0b busy=%0b rdy=%0b, expected 0 0 0 0 1",
                     out_valid, out_data, row_full, busy_flag, in_ready);
        end
        checks++;
        if ({w2_out_valid, w2_out_data, w2_row_full, w2_busy_flag} !== 12'd0) begin
            errors++;
            $display("[TB] FAIL reset_state_w2: got v=%0b d=%0d rf=%0b busy=%0b, expected all 0",
                     w2_out_valid, w2_out_data, w2_row_full, w2_busy_flag);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Feeds 0..15 back to back; assumes a freshly started block.
    task automatic test_steady();
        for (int i = 0; i < 16; i++) begin
            in_data = 8'(i); in_valid = 1'b1;
            @(posedge clk); #1;
            checks++;
            if (row_full !== (i >= 7)) begin
                errors++;
                $display("[TB] FAIL steady_row_full[%0d]: got %0b, expected %0b", i, row_full, (i >= 7));
            end
            checks++;
            if (out_valid !== (i >= 8)) begin
                errors++;
                $display("[TB] FAIL steady_out_valid[%0d]: got %0b, expected %0b", i, out_valid, (i >= 8));
            end
            if (i >= 8) begin
                checks++;
                if (out_data !== exp_steady[i-8]) begin
                    errors++;
                    $display("[TB] FAIL steady_out_data[%0d]: got %0d, expected %0d", i, out_data, exp_steady[i-8]);
                end
            end
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({out_valid, busy_flag} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL steady_drain: got v=%0b busy=%0b, expected v=0 busy=1", out_valid, busy_flag);
        end
    endtask

    task automatic test_max_values();
        reset_dut();
        for (int i = 0; i < 12; i++) begin
            in_data = 8'd255; in_valid = 1'b1;
            @(posedge clk); #1;
            checks++;
            if (out_valid !== (i >= 8)) begin
                errors++;
                $display("[TB] FAIL max_out_valid[%0d]: got %0b, expected %0b", i, out_valid, (i >= 8));
            end
            if (i >= 8) begin
                checks++;
                if (out_data !== 10'd765) begin
                    errors++;
                    $display("[TB] FAIL max_out_data[%0d]: got %0d, expected 765", i, out_data);
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        reset_dut();
        for (int i = 0; i < 9; i++) begin
            in_data = 8'(i); in_valid = 1'b1;
            @(posedge clk); #1;
        end
        out_ready = 1'b0; in_data = 8'd9; in_valid = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_in_ready: got %0b, expected 0", in_ready);
        end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checks++;
            if ({out_valid, out_data, in_ready} !== {1'b1, 10'd12, 1'b0}) begin
                errors++;
                $display("[TB] FAIL bp_hold[%0d]: got v=%0b d=%0d rdy=%0b, expected v=1 d=12 rdy=0",
                         c, out_valid, out_data, in_ready);
            end
        end
        out_ready = 1'b1;
        for (int i = 9; i < 12; i++) begin
            in_data = 8'(i); in_valid = 1'b1;
            @(posedge clk); #1;
            checks++;
            if ({out_valid, out_data} !== {1'b1, exp_steady[i-8]}) begin
                errors++;
                $display("[TB] FAIL bp_resume[%0d]: got v=%0b d=%0d, expected v=1 d=%0d",
                         i, out_valid, out_data, exp_steady[i-8]);
            end
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_no_duplicate: got v=%0b, expected 0", out_valid);
        end
    endtask

    task automatic test_clr();
        reset_dut();
        for (int i = 0; i < 6; i++) begin
            in_data = 8'(i); in_valid = 1'b1;
            @(posedge clk); #1;
        end
        clr = 1'b1; in_data = 8'd99; in_valid = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clr_in_ready: got %0b, expected 0", in_ready);
        end
        @(posedge clk); #1;
        clr = 1'b0;
        checks++;
        if ({row_full, busy_flag} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL clr_state: got rf=%0b busy=%0b, expected 0 0", row_full, busy_flag);
        end
        for (int i = 0; i < 12; i++) begin
            in_data = 8'(i); in_valid = 1'b1;
            @(posedge clk); #1;
            checks++;
            if (out_valid !== (i >= 8)) begin
                errors++;
                $display("[TB] FAIL clr_out_valid[%0d]: got %0b, expected %0b", i, out_valid, (i >= 8));
            end
            if (i >= 8) begin
                checks++;
                if (out_data !== exp_steady[i-8]) begin
                    errors++;
                    $display("[TB] FAIL clr_out_data[%0d]: got %0d, expected %0d", i, out_data, exp_steady[i-8]);
                end
            end
        end
        // A clr while a result is pending must not drop that result.
        in_valid = 1'b0; out_ready = 1'b0; clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        checks++;
        if ({out_valid, out_data, row_full} !== {1'b1, 10'd21, 1'b0}) begin
            errors++;
            $display("[TB] FAIL clr_pending: got v=%0b d=%0d rf=%0b, expected v=1 d=21 rf=0",
                     out_valid, out_data, row_full);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({out_valid, busy_flag} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL clr_delivered: got v=%0b busy=%0b, expected 0 0", out_valid, busy_flag);
        end
    endtask

    task automatic test_win2();
        reset_dut();
        for (int i = 0; i < 9; i++) begin
            w2_in_data = 8'(i + 1); w2_in_valid = 1'b1;
            @(posedge clk); #1;
            checks++;
            if (w2_row_full !== (i >= 2)) begin
                errors++;
                $display("[TB] FAIL w2_row_full[%0d]: got %0b, expected %0b", i, w2_row_full, (i >= 2));
            end
            checks++;
            if (w2_out_valid !== (i >= 3)) begin
                errors++;
                $display("[TB] FAIL w2_out_valid[%0d]: got %0b, expected %0b", i, w2_out_valid, (i >= 3));
            end
            if (i >= 3) begin
                checks++;
                if (w2_out_data !== exp_w2[i-3]) begin
                    errors++;
                    $display("[TB] FAIL w2_out_data[%0d]: got %0d, expected %0d", i, w2_out_data, exp_w2[i-3]);
                end
            end
        end
        w2_in_valid = 1'b0;
    endtask

    task automatic test_async_reset();
        reset_dut();
        for (int i = 0; i < 9; i++) begin
            in_data = 8'(i); in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, out_data, row_full, busy_flag} !== {1'b0, 10'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL async_reset: got v=%0b d=%0d rf=%0b busy=%0b, expected all 0",
                     out_valid, out_data, row_full, busy_flag);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_steady();
        test_max_values();
        test_backpressure();
        test_clr();
        test_win2();
        test_async_reset();
        test_steady();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
